// File: rtl/seed_rx_pkg.sv
// seed_rx_pkg
// Shared types and constants for the serial seed-load controller.
//   rx_state_t  - controller state encoding
//   SYNC_STAGES - depth of the clock-domain-crossing synchroniser
package seed_rx_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_END,
        VALID,
        ERR
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Brings one asynchronous pin into the clk domain through a SYNC_STAGES
// flop chain, then adds one register stage that produces the level and
// single-cycle rise/fall pulses, all cycle-aligned with each other.
// Ports:
//   clk, n_rst  - system clock, asynchronous active-low reset
//   async_in    - raw asynchronous input pin
//   level       - synchronised level (aligned with rise/fall)
//   rise, fall  - one-cycle pulses on a 0->1 / 1->0 transition of level
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    import seed_rx_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   warm_q;

    // warm_q fills with ones after reset. Edges are suppressed until the
    // chain has flushed, so a pin that already differs from RESET_VAL when
    // reset is released does not look like a fresh edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            warm_q <= '0;
            level  <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= warm_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~level;
            fall   <= warm_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  level;
        end
    end

endmodule

// File: rtl/seed_rx_ctrl.sv
// seed_rx_ctrl
// Serial seed-load controller for the Mersenne Twister core. Synchronises
// the three-wire serial link, drives an external WORD_BITS shift register
// one bit per ser_clk rise, checks frame length and hands the finished
// word to the MT seeding logic with a valid/ack handshake.
// Ports:
//   clk, n_rst     - system clock, asynchronous active-low reset
//   ser_clk        - external serial clock (data taken on its rise)
//   ser_data       - external serial data
//   ser_en_n       - external frame enable, active-low
//   seed_ack       - MT core has consumed the word
//   shift_enable   - one-cycle shift strobe to the shift register
//   shift_bit      - bit to shift in, valid with shift_enable
//   seed_valid     - shift register holds a complete, checked word
//   frame_err      - one-cycle pulse on short, long or overrun frame
//   busy           - a frame is being received
module seed_rx_ctrl #(
    parameter int WORD_BITS = 32
) (
    input  logic clk,
    input  logic n_rst,
    input  logic ser_clk,
    input  logic ser_data,
    input  logic ser_en_n,
    input  logic seed_ack,
    output logic shift_enable,
    output logic shift_bit,
    output logic seed_valid,
    output logic frame_err,
    output logic busy
);
    import seed_rx_pkg::*;

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

    logic clk_level, clk_rise, clk_fall;
    logic data_level, data_rise, data_fall;
    logic en_level, en_rise, en_fall;
    logic unused_edges;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             shift_enable_next, shift_bit_next, frame_err_next;

    sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (ser_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_data (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (ser_data),
        .level    (data_level),
        .rise     (data_rise),
        .fall     (data_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sync_en (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (ser_en_n),
        .level    (en_level),
        .rise     (en_rise),
        .fall     (en_fall)
    );

    // Synchroniser outputs that the controller has no use for.
    assign unused_edges = ^{clk_level, clk_fall, data_rise, data_fall};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            count        <= '0;
            shift_enable <= 1'b0;
            shift_bit    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            shift_enable <= shift_enable_next;
            shift_bit    <= shift_bit_next;
            frame_err    <= frame_err_next;
        end
    end

    // en_rise is tested before clk_rise so that a serial clock edge landing
    // in the same cycle as the end of frame is ignored. frame_err is
    // registered, so it is raised on the transition into ERR (and for an
    // overrun in VALID) and appears for exactly one cycle.
    always_comb begin
        state_next        = state;
        count_next        = count;
        shift_enable_next = 1'b0;
        shift_bit_next    = 1'b0;
        frame_err_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (en_fall) begin
                    state_next = SHIFT;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (en_rise) begin
                    state_next     = ERR;
                    frame_err_next = 1'b1;
                end else if (clk_rise && !en_level) begin
                    shift_enable_next = 1'b1;
                    shift_bit_next    = data_level;
                    count_next        = count + 1'b1;
                    if (count == LAST_BIT) begin
                        state_next = WAIT_END;
                    end
                end
            end
            WAIT_END: begin
                if (en_rise) begin
                    state_next = VALID;
                end else if (clk_rise && !en_level) begin
                    state_next     = ERR;
                    frame_err_next = 1'b1;
                end
            end
            VALID: begin
                // An ack in the same cycle as a new frame start hands over
                // directly, so the new frame is neither lost nor flagged.
                if (seed_ack) begin
                    if (en_fall) begin
                        state_next = SHIFT;
                        count_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (en_fall) begin
                    frame_err_next = 1'b1;
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign seed_valid = (state == VALID);
    assign busy       = (state == SHIFT) || (state == WAIT_END);

endmodule

// File: tb/tb_seed_rx_ctrl.sv
// tb_seed_rx_ctrl
// Self-checking bench for seed_rx_ctrl. Frames are driven on the serial
// pins; a negedge monitor records what the controller did and each frame
// is compared against the outcome expected from its length and contents.
module tb_seed_rx_ctrl;

    localparam int WORD_BITS = 32;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic ser_clk = 1'b0;
    logic ser_data = 1'b0;
    logic ser_en_n = 1'b1;
    logic seed_ack = 1'b0;
    logic shift_enable, shift_bit, seed_valid, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int half = 4;

    logic [63:0] got_word;
    int got_shifts, se_viol, err_pulses, err_run, max_err_run;
    int first_shift_cyc, first_err_cyc, en_rise_cyc;
    int rise_cyc[$];
    logic prev_se = 1'b0;

    seed_rx_ctrl #(.WORD_BITS(WORD_BITS)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .ser_clk      (ser_clk),
        .ser_data     (ser_data),
        .ser_en_n     (ser_en_n),
        .seed_ack     (seed_ack),
        .shift_enable (shift_enable),
        .shift_bit    (shift_bit),
        .seed_valid   (seed_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collects shifted bits, strobe spacing and error pulses.
    always @(negedge clk) begin
        if (shift_enable) begin
            got_word = {got_word[62:0], shift_bit};
            if (got_shifts == 0) first_shift_cyc = cyc;
            got_shifts++;
            if (prev_se) se_viol++;
        end
        if (frame_err) begin
            err_run++;
            if (err_run == 1) begin
                err_pulses++;
                if (first_err_cyc < 0) first_err_cyc = cyc;
            end
            if (err_run > max_err_run) max_err_run = err_run;
        end else begin
            err_run = 0;
        end
        prev_se = shift_enable;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearMonitor();
        got_word = '0;
        got_shifts = 0;
        se_viol = 0;
        err_pulses = 0;
        err_run = 0;
        max_err_run = 0;
        first_shift_cyc = -1;
        first_err_cyc = -1;
        rise_cyc.delete();
    endtask

    task automatic sendBit(input logic b);
        ser_data = b;
        tick(half);
        ser_clk = 1'b1;
        rise_cyc.push_back(cyc);
        tick(half);
        ser_clk = 1'b0;
    endtask

    // Drives one frame, MSB first, nbits long.
    task automatic applyStimulus(input logic [63:0] data, input int nbits, input bit raise_en);
        ser_en_n = 1'b0;
        tick(half);
        for (int i = nbits - 1; i >= 0; i--) sendBit(data[i]);
        tick(half);
        if (raise_en) begin
            ser_en_n = 1'b1;
            en_rise_cyc = cyc;
        end
    endtask

    // Reference outcome: a frame of exactly WORD_BITS is delivered; shorter
    // ones shift all their bits then error; longer ones shift the first
    // WORD_BITS bits then error on the next ser_clk rise.
    task automatic checkFrame(input logic [63:0] data, input int nbits, input string tag);
        logic [31:0] exp_word;
        int exp_shifts;
        bit good;
        good = (nbits == WORD_BITS);
        exp_shifts = (nbits < WORD_BITS) ? nbits : WORD_BITS;
        if (nbits >= WORD_BITS) exp_word = 32'(data >> (nbits - WORD_BITS));
        else exp_word = 32'(data & ((64'd1 << nbits) - 64'd1));
        if (good) begin
            tick(3);
            checkOutput({tag, "_valid_early"}, 64'(seed_valid), 64'd0);
            tick(1);
            checkOutput({tag, "_valid_latency"}, 64'(seed_valid), 64'd1);
            tick(4);
        end else begin
            tick(8);
            checkOutput({tag, "_valid"}, 64'(seed_valid), 64'd0);
            checkOutput({tag, "_err_width"}, 64'(max_err_run), 64'd1);
            if (nbits < WORD_BITS)
                checkOutput({tag, "_err_latency"}, 64'(first_err_cyc - en_rise_cyc), 64'd4);
            else
                checkOutput({tag, "_err_latency"}, 64'(first_err_cyc - rise_cyc[WORD_BITS]), 64'd4);
        end
        checkOutput({tag, "_shifts"}, 64'(got_shifts), 64'(exp_shifts));
        checkOutput({tag, "_word"}, 64'(got_word[31:0]), 64'(exp_word));
        checkOutput({tag, "_err_pulses"}, 64'(err_pulses), good ? 64'd0 : 64'd1);
        checkOutput({tag, "_se_spacing"}, 64'(se_viol), 64'd0);
        checkOutput({tag, "_shift_latency"}, 64'(first_shift_cyc - rise_cyc[0]), 64'd4);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic runFrame(input logic [63:0] data, input int nbits, input string tag);
        clearMonitor();
        applyStimulus(data, nbits, 1'b1);
        checkFrame(data, nbits, tag);
    endtask

    task automatic ackWord(input string tag);
        checkOutput({tag, "_valid_before_ack"}, 64'(seed_valid), 64'd1);
        seed_ack = 1'b1;
        tick(1);
        checkOutput({tag, "_valid_after_ack"}, 64'(seed_valid), 64'd0);
        seed_ack = 1'b0;
        tick(3);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] data;
        int nbits;
        clearMonitor();
        tick(3);
        checkOutput("reset_shift_enable", 64'(shift_enable), 64'd0);
        checkOutput("reset_shift_bit", 64'(shift_bit), 64'd0);
        checkOutput("reset_seed_valid", 64'(seed_valid), 64'd0);
        checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        n_rst = 1'b1;
        tick(6);

        half = 4;
        runFrame(64'h1571_9A3C, 32, "nominal");
        tick(5);
        checkOutput("nominal_valid_held", 64'(seed_valid), 64'd1);
        ackWord("nominal");

        runFrame({32'd0, $urandom}, 20, "short");
        runFrame({32'd0, $urandom}, 32, "after_short");
        ackWord("after_short");

        runFrame({$urandom, $urandom}, 33, "long");

        data = {32'd0, $urandom};
        runFrame(data, 32, "pre_overrun");
        clearMonitor();
        applyStimulus({32'd0, $urandom}, 32, 1'b1);
        tick(8);
        checkOutput("overrun_shifts", 64'(got_shifts), 64'd0);
        checkOutput("overrun_err_pulses", 64'(err_pulses), 64'd1);
        checkOutput("overrun_err_width", 64'(max_err_run), 64'd1);
        checkOutput("overrun_valid", 64'(seed_valid), 64'd1);
        ackWord("overrun");
        runFrame({32'd0, $urandom}, 32, "post_overrun");
        ackWord("post_overrun");

        runFrame({32'd0, $urandom}, 32, "pre_collide");
        clearMonitor();
        data = {32'd0, $urandom};
        fork
            applyStimulus(data, 32, 1'b1);
            begin
                tick(3);
                seed_ack = 1'b1;
                tick(1);
                seed_ack = 1'b0;
            end
        join
        checkFrame(data, 32, "collide");
        ackWord("collide");

        clearMonitor();
        ser_en_n = 1'b0;
        tick(half);
        for (int i = 0; i < 10; i++) sendBit(1'($urandom));
        checkOutput("busy_mid_frame", 64'(busy), 64'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("midreset_shift_enable", 64'(shift_enable), 64'd0);
        checkOutput("midreset_shift_bit", 64'(shift_bit), 64'd0);
        checkOutput("midreset_seed_valid", 64'(seed_valid), 64'd0);
        checkOutput("midreset_frame_err", 64'(frame_err), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        tick(2);
        n_rst = 1'b1;
        clearMonitor();
        for (int i = 0; i < 12; i++) sendBit(1'($urandom));
        tick(half);
        ser_en_n = 1'b1;
        tick(8);
        checkOutput("stale_frame_shifts", 64'(got_shifts), 64'd0);
        checkOutput("stale_frame_err", 64'(err_pulses), 64'd0);
        checkOutput("stale_frame_valid", 64'(seed_valid), 64'd0);
        runFrame(64'hFFFF_0000, 32, "after_reset");
        ackWord("after_reset");

        for (int k = 0; k < 8; k++) begin
            half = $urandom_range(3, 6);
            data = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0, 1: nbits = 32;
                2: nbits = $urandom_range(1, 31);
                default: nbits = $urandom_range(33, 36);
            endcase
            runFrame(data, nbits, $sformatf("rand%0d_len%0d", k, nbits));
            if (nbits == WORD_BITS) begin
                tick($urandom_range(0, 10));
                ackWord($sformatf("rand%0d", k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seed_rx_ctrl.md
# seed_rx_ctrl

Serial seed-load controller for the Mersenne Twister core. It synchronises an external three-wire serial link (ser_clk, ser_data, ser_en_n) into the clk domain and sequences a NUM_BITS-wide serial-to-parallel shift register through shift_enable/shift_bit. It checks frame length and presents the completed word to the MT seeding logic with a valid/ack handshake. It sits between the chip pins and the seed register feeding the twister state initialiser.

## Interface
- WORD_BITS, 32, bits per frame; must equal NUM_BITS of the driven shift register
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- ser_clk  in  1  external serial clock, asynchronous to clk; data sampled on its rising edge
- ser_data  in  1  external serial data, asynchronous
- ser_en_n  in  1  external frame enable, active-low, asynchronous
- seed_ack  in  1  MT core has consumed the word; sampled only while seed_valid=1
- shift_enable  out  1  one-cycle shift strobe to the shift register
- shift_bit  out  1  serial bit to the shift register; meaningful only while shift_enable=1
- seed_valid  out  1  shift register holds a complete, length-checked word
- frame_err  out  1  one-cycle pulse on a short, long or overrun frame
- busy  out  1  high in SHIFT and WAIT_END

## Operation
- Each async input passes through a 2-flop synchroniser. Reset levels: ser_clk 0, ser_data 0, ser_en_n 1.
- One more register stage per input provides edge detection: clk_rise (synced ser_clk 0->1), en_fall, en_rise.
- Bit counter: width $clog2(WORD_BITS+1). Cleared on entry to SHIFT. Increments on each accepted shift.
- States: IDLE, SHIFT, WAIT_END, VALID, ERR.
- IDLE: en_fall -> SHIFT. A frame already in progress (en low with no fall seen) is ignored.
- SHIFT, on clk_rise with synced en low:
  - shift_enable=1 and shift_bit=synced ser_data for one cycle; count+1.
  - When count reaches WORD_BITS, go to WAIT_END.
- SHIFT, en_rise before count reaches WORD_BITS -> ERR (short frame).
- WAIT_END: en_rise -> VALID. clk_rise while en low -> ERR (long frame); no shift issued.
- VALID:
  - seed_valid=1, held until seed_ack. shift_enable is forced 0.
  - seed_ack -> IDLE.
  - en_fall without seed_ack: frame_err pulses one cycle (overrun), state stays VALID, and that frame's bits are dropped.
- ERR: frame_err=1 for exactly one cycle, then IDLE. Shift register contents are undefined; the downstream block only trusts them under seed_valid.
- Simultaneous events:
  - SHIFT or WAIT_END: en_rise takes priority over clk_rise in the same cycle; the clk edge is ignored.
  - VALID: seed_ack together with en_fall -> SHIFT with count 0, and no frame_err.
- Reset mid-frame: all state is discarded. After reset, a new frame is accepted only after a fresh en_fall.

## Timing
- Reset values: shift_enable 0, shift_bit 0, seed_valid 0, frame_err 0, busy 0, state IDLE, count 0.
- Latency from a pin edge to the internal edge pulse is 3 clk cycles: 2 synchroniser flops plus 1 edge register.
- shift_enable is registered. It is high in the cycle after clk_rise is detected, i.e. the 4th clk edge after the ser_clk rise, and never high on two consecutive cycles.
- shift_bit is a registered copy of the synchronised ser_data at clk_rise; it is cycle-aligned with shift_enable.
- seed_valid rises on the clk edge after en_rise is detected in WAIT_END. It falls on the clk edge after seed_ack is sampled high.
- Link constraints:
  - ser_clk high and low phases each ≥ 3 clk periods.
  - ser_data stable ≥ 3 clk periods before and after the ser_clk rise.
  - ser_en_n setup/hold to the first and last ser_clk rise ≥ 3 clk periods.
- Throughput is one bit per ser_clk period. Minimum frame is WORD_BITS × 6 clk cycles.

## Structure
- Package seed_rx_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, SHIFT, WAIT_END, VALID, ERR}
  - localparam SYNC_STAGES = 2
- Sub-module sync_edge: a SYNC_STAGES synchroniser plus edge register with a parameterised reset level. Outputs: level, rise, fall. Instantiate three times.
- The shift register is external. The top-level wrapper connects shift_enable/shift_bit to it and seeds the MT core from its parallel output.

## Test plan
- Nominal: 32-bit frame 0x1571_9A3C with ser_clk period 8 clk → exactly 32 shift_enable pulses; shift_bit sequence equals the frame bits in order; seed_valid=1 4 clk after ser_en_n rises; held for 10 cycles until seed_ack, then 0 the next cycle.
- Short frame: 20 ser_clk edges, then ser_en_n high → frame_err pulses exactly one cycle, seed_valid stays 0, state returns to IDLE; a following full frame yields seed_valid.
- Long frame: 33 ser_clk edges → 32 shift_enable pulses only, frame_err one cycle after the 33rd edge is detected, no seed_valid.
- Overrun: a new frame starts while seed_valid=1 with no ack → frame_err pulse, zero shift_enable, seed_valid still 1; after ack, the next clean frame is accepted.
- Ack/start collision: seed_ack and a detected en_fall in the same cycle → no frame_err, the frame shifts all 32 bits, and seed_valid reasserts after the frame.
- Reset mid-frame: assert n_rst after 10 bits → all outputs 0 immediately; a frame with ser_en_n already low is ignored; the next full frame of 0xFFFF_0000 produces the correct 32 shifts and seed_valid.
